arashi_mem_wr_arb: RTL and testbench
====================================

Name: arashi_mem_wr_arb

Overview:
- Round-robin write arbiter and initialiser in front of arashi_mem.
- arashi_mem has a single physical write port, driven from lane 0 of its packed per-thread buses. This block shares that port among THREAD_NUM requester threads.
- After reset it sweeps the whole memory with zeros, then arbitrates thread writes.
- All memory-side outputs are registered, so lane 0 carries one write per cycle.

Parameters:
- DATA_WIDTH, 32, width of one memory word.
- MEM_WIDTH, 4, address width; DEPTH = 1<<MEM_WIDTH.
- THREAD_NUM, 4, number of requesting threads; must be >= 1.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- req_valid  input  THREAD_NUM  per-thread write request.
- req_addr  input  MEM_WIDTH*THREAD_NUM  packed per-thread address; thread i at [i*MEM_WIDTH +: MEM_WIDTH].
- req_data  input  DATA_WIDTH*THREAD_NUM  packed per-thread data; thread i at [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  output  THREAD_NUM  one-hot grant, combinational from state, req_valid and rr_ptr.
- mem_wr  output  THREAD_NUM  to arashi_mem wr; only bit 0 is ever driven, bits above are 0.
- mem_waddr  output  MEM_WIDTH*THREAD_NUM  to arashi_mem waddr; lane 0 only, upper lanes 0.
- mem_wdata  output  DATA_WIDTH*THREAD_NUM  to arashi_mem wdata; lane 0 only, upper lanes 0.
- init_done  output  1  high once the zero sweep has been issued.
- stat_conflicts  output  32  contention counter (see Optional Feature).

Behaviour:
- Reset (rst=1 at an edge):
  - state=INIT, sweep cnt=0, rr_ptr=0.
  - mem_wr=0, mem_waddr=0, mem_wdata=0, init_done=0, stat_conflicts=0.
  - req_ready=0 while rst=1 or state=INIT.
- INIT state:
  - Each edge registers mem_wr[0]=1, lane-0 waddr=cnt, wdata=0, then cnt++.
  - Writes appear at waddr 0,1,...,DEPTH-1 on DEPTH consecutive cycles, the first one cycle after the first edge with rst=0.
  - The edge that registers the cnt==DEPTH-1 write also sets state=RUN and init_done=1.
  - req_valid is ignored during INIT; requesters simply wait.
- RUN state, arbitration:
  - g = first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo THREAD_NUM.
  - req_ready[g]=1, all other bits 0. If no req_valid is set, req_ready=0.
- RUN state, transfer:
  - On an edge with req_valid[g] & req_ready[g], register mem_wr[0]=1, waddr=req_addr[g], wdata=req_data[g].
  - Latency from accept to the write at mem_* outputs is one cycle.
  - Set rr_ptr = (g+1) mod THREAD_NUM.
- RUN state, idle edge: mem_wr[0]=0. mem_waddr and mem_wdata hold their previous value; they are don't-care when mem_wr=0. rr_ptr is unchanged.
- Handshake:
  - A requester holds req_valid, addr and data stable until it sees ready.
  - req_valid is not required to depend on req_ready; no combinational path from req_ready back to req_valid is allowed.
  - Dropping req_valid before grant is legal and leaves no side effect.
- Fairness: a continuously valid thread is granted within THREAD_NUM cycles. A thread is never granted twice while another continuously valid thread waits.
- THREAD_NUM=1: rr_ptr stays 0; thread 0 is granted every cycle it is valid.
- Same address from two threads: the writes are serialised in grant order, so the later grant wins in memory.
- rst mid-sweep or mid-RUN: any in-flight grant is discarded; the block returns to INIT and re-sweeps from address 0.
- init_done never falls except on reset.

Optional Feature:
- Macro: ARASHI_MEM_WR_ARB_STAT_EN.
- Defined: stat_conflicts increments by 1 on each RUN edge where popcount(req_valid)>=2. It saturates at 32'hFFFF_FFFF and clears on rst.
- Undefined: no counter logic is built; stat_conflicts is tied to 0.

Test Plan:
- Reset then release with defaults (DEPTH=16) -> mem_wr[0]=1 with waddr 0..15 and wdata 0 on 16 consecutive cycles. init_done rises with the waddr=15 write. req_ready stays 0 throughout INIT even with req_valid=4'hF.
- After init, thread 2 alone valid (addr 5, data 32'hDEADBEEF) -> req_ready=4'b0100 the same cycle. The next cycle shows mem_wr=4'b0001, lane-0 waddr=5, wdata=32'hDEADBEEF. rr_ptr becomes 3.
- req_valid=4'hF held with rr_ptr=0 -> grants in order 0,1,2,3,0 on consecutive cycles, with mem_wr[0]=1 every cycle from the second cycle.
- Threads 1 and 3 both write addr 7 (data 1 and 3), rr_ptr=2 -> thread 3 is granted first, then thread 1. Memory word 7 ends at 1.
- rst asserted on the cycle thread 0 is granted -> no mem_wr from that grant, INIT restarts at waddr 0, init_done=0.
- With ARASHI_MEM_WR_ARB_STAT_EN, 10 RUN cycles with req_valid=4'b0011 followed by 5 cycles with 4'b0001 -> stat_conflicts=10. Without the macro, stat_conflicts=0.

Source files
------------

// File: rtl/arashi_mem_wr_arb.sv
// Round-robin write arbiter and zero-initialiser sharing arashi_mem's lane-0 write port.
// Optional contention counter: define ARASHI_MEM_WR_ARB_STAT_EN.
module arashi_mem_wr_arb #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_WIDTH  = 4,
  parameter int THREAD_NUM = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [THREAD_NUM-1:0]            req_valid,
  input  logic [MEM_WIDTH*THREAD_NUM-1:0]  req_addr,
  input  logic [DATA_WIDTH*THREAD_NUM-1:0] req_data,
  output logic [THREAD_NUM-1:0]            req_ready,
  output logic [THREAD_NUM-1:0]            mem_wr,
  output logic [MEM_WIDTH*THREAD_NUM-1:0]  mem_waddr,
  output logic [DATA_WIDTH*THREAD_NUM-1:0] mem_wdata,
  output logic                             init_done,
  output logic [31:0]                      stat_conflicts
);

  localparam int DEPTH = 1 << MEM_WIDTH;
  localparam int PTR_W = (THREAD_NUM > 1) ? $clog2(THREAD_NUM) : 1;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                  state_q, state_d;
  logic [MEM_WIDTH-1:0]    cnt_q, cnt_d;
  logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic                    mem_wr_q, mem_wr_d;
  logic [MEM_WIDTH-1:0]    waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    init_done_q, init_done_d;

  logic [THREAD_NUM-1:0]   grant;
  logic                    grant_vld;
  logic [PTR_W-1:0]        grant_idx;

  // First valid requester found scanning upward from rr_ptr, wrapping at THREAD_NUM.
  always_comb begin
    int idx;
    grant     = '0;
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int k = 0; k < THREAD_NUM; k++) begin
      idx = (int'(rr_ptr_q) + k) % THREAD_NUM;
      if (!grant_vld && req_valid[idx]) begin
        grant_vld = 1'b1;
        grant_idx = PTR_W'(idx);
      end
    end
    if (grant_vld) grant[grant_idx] = 1'b1;
  end

  assign req_ready = (state_q == ST_RUN && !rst) ? grant : '0;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rr_ptr_d    = rr_ptr_q;
    mem_wr_d    = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    init_done_d = init_done_q;
    case (state_q)
      ST_INIT: begin
        mem_wr_d = 1'b1;
        waddr_d  = cnt_q;
        wdata_d  = '0;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == MEM_WIDTH'(DEPTH - 1)) begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (grant_vld) begin
          mem_wr_d = 1'b1;
          waddr_d  = req_addr[grant_idx*MEM_WIDTH +: MEM_WIDTH];
          wdata_d  = req_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
          rr_ptr_d = (grant_idx == PTR_W'(THREAD_NUM - 1)) ? '0 : grant_idx + 1'b1;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      rr_ptr_q    <= '0;
      mem_wr_q    <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      mem_wr_q    <= mem_wr_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      init_done_q <= init_done_d;
    end
  end

  // Only lane 0 of the memory buses is physically wired to the write port.
  genvar gi;
  generate
    for (gi = 0; gi < THREAD_NUM; gi++) begin : g_lane
      if (gi == 0) begin : g_live
        assign mem_wr[gi]                             = mem_wr_q;
        assign mem_waddr[gi*MEM_WIDTH +: MEM_WIDTH]   = waddr_q;
        assign mem_wdata[gi*DATA_WIDTH +: DATA_WIDTH] = wdata_q;
      end else begin : g_tied
        assign mem_wr[gi]                             = 1'b0;
        assign mem_waddr[gi*MEM_WIDTH +: MEM_WIDTH]   = '0;
        assign mem_wdata[gi*DATA_WIDTH +: DATA_WIDTH] = '0;
      end
    end
  endgenerate

  assign init_done = init_done_q;

`ifdef ARASHI_MEM_WR_ARB_STAT_EN
  logic [31:0] stat_q, stat_d;

  always_comb begin
    int pop;
    pop = 0;
    for (int k = 0; k < THREAD_NUM; k++) pop += int'(req_valid[k]);
    stat_d = stat_q;
    if (state_q == ST_RUN && pop >= 2 && stat_q != 32'hFFFF_FFFF) stat_d = stat_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) stat_q <= '0;
    else     stat_q <= stat_d;
  end

  assign stat_conflicts = stat_q;
`else
  assign stat_conflicts = '0;
`endif

endmodule

// File: tb/tb_arashi_mem_wr_arb.sv
// Scoreboard bench for arashi_mem_wr_arb: expected writes queued at grant time,
// popped and compared whenever lane 0 shows a write.
module tb_arashi_mem_wr_arb;
  localparam int DW = 32;
  localparam int MW = 4;
  localparam int TN = 4;

  typedef struct packed {
    logic [MW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [TN-1:0]     req_valid = '0;
  logic [MW*TN-1:0]  req_addr = '0;
  logic [DW*TN-1:0]  req_data = '0;
  logic [TN-1:0]     req_ready;
  logic [TN-1:0]     mem_wr;
  logic [MW*TN-1:0]  mem_waddr;
  logic [DW*TN-1:0]  mem_wdata;
  logic              init_done;
  logic [31:0]       stat_conflicts;

  int   n_checks = 0;
  int   n_errors = 0;
  wr_t  exp_q[$];
  wr_t  mon_e;
  logic [DW-1:0] obs_mem [16];

  arashi_mem_wr_arb #(.DATA_WIDTH(DW), .MEM_WIDTH(MW), .THREAD_NUM(TN)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready),
    .mem_wr(mem_wr), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .init_done(init_done), .stat_conflicts(stat_conflicts)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every lane-0 write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (mem_wr[0] === 1'b1) begin
      $display("wr addr=%0h data=%08h", mem_waddr[MW-1:0], mem_wdata[DW-1:0]);
      if (exp_q.size() == 0) begin
        check_eq("sb_unexpected_wr", 64'(1), 64'(0));
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("wr_addr", 64'(mem_waddr[MW-1:0]), 64'(mon_e.a));
        check_eq("wr_data", 64'(mem_wdata[DW-1:0]), 64'(mon_e.d));
      end
      check_eq("upper_lanes", 64'(|{mem_wr[TN-1:1], mem_waddr[MW*TN-1:MW], mem_wdata[DW*TN-1:DW]}), 64'(0));
      obs_mem[mem_waddr[MW-1:0]] = mem_wdata[DW-1:0];
    end
  end

  task automatic set_req(input int t, input logic [MW-1:0] a, input logic [DW-1:0] d);
    req_addr[t*MW +: MW] = a;
    req_data[t*DW +: DW] = d;
  endtask

  // Called just after a negedge with inputs set; checks the grant and queues its write.
  task automatic cycle_expect(input logic [TN-1:0] exp_rdy);
    wr_t e;
    #1;
    check_eq("req_ready", 64'(req_ready), 64'(exp_rdy));
    for (int t = 0; t < TN; t++) begin
      if (exp_rdy[t]) begin
        e.a = req_addr[t*MW +: MW];
        e.d = req_data[t*DW +: DW];
        exp_q.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  task automatic reset_sweep();
    wr_t e;
    rst = 1'b1;
    #1;
    check_eq("ready_in_rst", 64'(req_ready), 64'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_mem_wr", 64'(mem_wr), 64'(0));
    check_eq("rst_waddr", 64'(mem_waddr), 64'(0));
    check_eq("rst_wdata_lane0", 64'(mem_wdata[DW-1:0]), 64'(0));
    check_eq("rst_init_done", 64'(init_done), 64'(0));
    check_eq("rst_stat", 64'(stat_conflicts), 64'(0));
    for (int i = 0; i < 16; i++) begin
      e.a = MW'(i);
      e.d = '0;
      exp_q.push_back(e);
    end
    rst = 1'b0;
    req_valid = 4'hF;
    for (int t = 0; t < TN; t++) set_req(t, MW'($urandom_range(15)), $urandom);
    #1;
    check_eq("ready_init", 64'(req_ready), 64'(0));
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      check_eq("init_done", 64'(init_done), 64'(k == 16));
      if (k < 16) check_eq("ready_init", 64'(req_ready), 64'(0));
    end
    req_valid = '0;
  endtask

  initial begin
    int exp_stat;
    // Reset and zero sweep
    reset_sweep();

    // Thread 2 alone
    set_req(2, 4'd5, 32'hDEAD_BEEF);
    req_valid = 4'b0100;
    cycle_expect(4'b0100);
    req_valid = '0;
    cycle_expect(4'b0000);

    // All valid: rr_ptr=3 after thread 2, then full rotation
    for (int t = 0; t < TN; t++) set_req(t, MW'(8 + t), 32'hA000_0000 + 32'(t));
    req_valid = 4'hF;
    cycle_expect(4'b1000);
    cycle_expect(4'b0001);
    cycle_expect(4'b0010);
    cycle_expect(4'b0100);
    cycle_expect(4'b1000);
    cycle_expect(4'b0001);
    req_valid = '0;

    // Same-address race from threads 1 and 3 with rr_ptr moved to 2
    set_req(1, 4'd0, 32'h11);
    req_valid = 4'b0010;
    cycle_expect(4'b0010);
    set_req(1, 4'd7, 32'd1);
    set_req(3, 4'd7, 32'd3);
    req_valid = 4'b1010;
    cycle_expect(4'b1000);
    req_valid = 4'b0010;
    cycle_expect(4'b0010);
    req_valid = '0;
    cycle_expect(4'b0000);
    cycle_expect(4'b0000);
    check_eq("mem7_last_grant_wins", 64'(obs_mem[7]), 64'(1));

    // Reset on the cycle thread 0 would be granted
    set_req(0, 4'd3, 32'h55);
    req_valid = 4'b0001;
    #1;
    check_eq("ready_pre_rst", 64'(req_ready), 64'(4'b0001));
    reset_sweep();

    // Contention counter
    set_req(0, 4'd1, 32'hC0);
    set_req(1, 4'd2, 32'hC1);
    req_valid = 4'b0011;
    for (int i = 0; i < 10; i++) cycle_expect((i % 2 == 0) ? 4'b0001 : 4'b0010);
    req_valid = 4'b0001;
    for (int i = 0; i < 5; i++) cycle_expect(4'b0001);
    req_valid = '0;
    cycle_expect(4'b0000);
    cycle_expect(4'b0000);
`ifdef ARASHI_MEM_WR_ARB_STAT_EN
    exp_stat = 10;
`else
    exp_stat = 0;
`endif
    check_eq("stat_conflicts", 64'(stat_conflicts), 64'(exp_stat));
    check_eq("init_done_held", 64'(init_done), 64'(1));
    check_eq("sb_empty", 64'(exp_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
